// File: rtl/clk_period_monitor.sv
// Measures the period of a hub-generated clock in fundamental-clock cycles,
// flags out-of-tolerance periods and a stalled input.
module clk_period_monitor #(
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned EXP_PERIOD = 10,
  parameter int unsigned TOLERANCE  = 0,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned ERR_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 meas_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  output logic                 period_ok,
  output logic                 freq_err,
  output logic                 stuck,
  output logic [ERR_WIDTH-1:0] err_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARM     = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;

  // Lower bound saturates at zero when the tolerance exceeds the expected period
  localparam int unsigned LO_BOUND = (TOLERANCE > EXP_PERIOD) ? 0 : (EXP_PERIOD - TOLERANCE);
  localparam int unsigned HI_BOUND = EXP_PERIOD + TOLERANCE;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);

  logic                 s1, s2, s3;
  logic [1:0]           state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0] period_nxt;
  logic                 valid_nxt, ok_nxt, ferr_nxt, stuck_nxt;
  logic [ERR_WIDTH-1:0] ecnt_nxt;
  logic                 rise;
  logic                 in_range;
  logic                 timeout_hit;
  logic [31:0]          cnt_ext;

  assign rise        = s2 & ~s3;
  assign cnt_ext     = 32'(cnt);
  assign in_range    = (cnt_ext >= LO_BOUND) && (cnt_ext <= HI_BOUND);
  assign timeout_hit = (cnt == TIMEOUT_CNT);

  // Synchroniser, state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      state        <= S_IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      period_ok    <= 1'b0;
      freq_err     <= 1'b0;
      stuck        <= 1'b0;
      err_count    <= '0;
    end else begin
      s1           <= meas_in;
      s2           <= s1;
      s3           <= s2;
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      period       <= period_nxt;
      period_valid <= valid_nxt;
      period_ok    <= ok_nxt;
      freq_err     <= ferr_nxt;
      stuck        <= stuck_nxt;
      err_count    <= ecnt_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    period_nxt = period;
    valid_nxt  = 1'b0;
    ok_nxt     = period_ok;
    ferr_nxt   = freq_err;
    stuck_nxt  = stuck;
    ecnt_nxt   = err_count;

    if (!enable) begin
      state_nxt  = S_IDLE;
      cnt_nxt    = '0;
      period_nxt = '0;
      ok_nxt     = 1'b0;
      ferr_nxt   = 1'b0;
      stuck_nxt  = 1'b0;
      ecnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt  = S_ARM;
          cnt_nxt    = '0;
          period_nxt = '0;
          ok_nxt     = 1'b0;
          ferr_nxt   = 1'b0;
          stuck_nxt  = 1'b0;
          ecnt_nxt   = '0;
        end
        S_ARM: begin
          // First edge only provides the reference; a rise beats a coincident timeout
          if (rise) begin
            state_nxt = S_MEASURE;
            cnt_nxt   = CNT_WIDTH'(1);
            stuck_nxt = 1'b0;
          end else if (timeout_hit) begin
            stuck_nxt = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_WIDTH'(1);
          end
        end
        S_MEASURE: begin
          if (rise) begin
            cnt_nxt    = CNT_WIDTH'(1);
            period_nxt = cnt;
            valid_nxt  = 1'b1;
            ok_nxt     = in_range;
            if (!in_range) begin
              ferr_nxt = 1'b1;
              if (!(&err_count)) begin
                ecnt_nxt = err_count + ERR_WIDTH'(1);
              end
            end
          end else if (timeout_hit) begin
            state_nxt = S_ARM;
            stuck_nxt = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor: two instances (tolerance 0 and 1)
// share stimulus; every reported period is checked against a hand-built queue.
module tb_clk_period_monitor;

  typedef struct packed {
    logic [15:0] period;
    logic        ok;
    logic        ferr;
    logic [1:0]  ecnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset, enable, meas_in;

  logic [15:0] a_period, b_period;
  logic        a_valid, a_ok, a_ferr, a_stuck;
  logic        b_valid, b_ok, b_ferr, b_stuck;
  logic [1:0]  a_ecnt, b_ecnt;

  int   n_checks = 0;
  int   n_errors = 0;
  int   a_seen = 0, b_seen = 0, n_pushed = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  clk_period_monitor #(.CNT_WIDTH(16), .EXP_PERIOD(10), .TOLERANCE(0), .TIMEOUT(64), .ERR_WIDTH(2)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .meas_in(meas_in),
    .period(a_period), .period_valid(a_valid), .period_ok(a_ok),
    .freq_err(a_ferr), .stuck(a_stuck), .err_count(a_ecnt)
  );

  clk_period_monitor #(.CNT_WIDTH(16), .EXP_PERIOD(10), .TOLERANCE(1), .TIMEOUT(64), .ERR_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .meas_in(meas_in),
    .period(b_period), .period_valid(b_valid), .period_ok(b_ok),
    .freq_err(b_ferr), .stuck(b_stuck), .err_count(b_ecnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Queue one expected report for each instance
  task automatic expect2(input int p, input logic aok, input logic afe, input int aec,
                         input logic bok, input logic bfe, input int bec);
    qa.push_back('{period: 16'(p), ok: aok, ferr: afe, ecnt: 2'(aec)});
    qb.push_back('{period: 16'(p), ok: bok, ferr: bfe, ecnt: 2'(bec)});
    n_pushed++;
  endtask

  // Advance one cycle and check any reported period against the queues
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (a_valid) begin
      a_seen++;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_period", 32'(a_period), 32'(e.period));
        chk("a_ok",     32'(a_ok),     32'(e.ok));
        chk("a_ferr",   32'(a_ferr),   32'(e.ferr));
        chk("a_ecnt",   32'(a_ecnt),   32'(e.ecnt));
      end
    end
    if (b_valid) begin
      b_seen++;
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_period", 32'(b_period), 32'(e.period));
        chk("b_ok",     32'(b_ok),     32'(e.ok));
        chk("b_ferr",   32'(b_ferr),   32'(e.ferr));
        chk("b_ecnt",   32'(b_ecnt),   32'(e.ecnt));
      end
    end
  endtask

  task automatic wave(input int len, input int hi);
    meas_in = 1'b1;
    repeat (hi) tick();
    meas_in = 1'b0;
    repeat (len - hi) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_period"}, 32'(a_period), 32'd0);
    chk({tag, "_a_valid"},  32'(a_valid),  32'd0);
    chk({tag, "_a_ok"},     32'(a_ok),     32'd0);
    chk({tag, "_a_ferr"},   32'(a_ferr),   32'd0);
    chk({tag, "_a_stuck"},  32'(a_stuck),  32'd0);
    chk({tag, "_a_ecnt"},   32'(a_ecnt),   32'd0);
    chk({tag, "_b_ferr"},   32'(b_ferr),   32'd0);
    chk({tag, "_b_ecnt"},   32'(b_ecnt),   32'd0);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_a_valid_count"}, 32'(a_seen), 32'(n_pushed));
    chk({tag, "_b_valid_count"}, 32'(b_seen), 32'(n_pushed));
  endtask

  // Closing rise, then a one-cycle disable that must clear all status
  task automatic break_section(input string tag);
    meas_in = 1'b1;
    repeat (4) tick();
    meas_in = 1'b0;
    repeat (4) tick();
    chk_counts(tag);
    enable = 1'b0;
    tick();
    chk_zero({tag, "_disable"});
    enable = 1'b1;
    tick();
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    meas_in = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();
    chk_zero("idle");
    enable = 1'b1;
    tick();

    // Nominal 10-cycle clock, one stretched period, then recovery
    for (int i = 0; i < 8; i++) expect2(10, 1'b1, 1'b0, 0, 1'b1, 1'b0, 0);
    expect2(12, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1);
    expect2(10, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1);
    expect2(10, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1);
    for (int i = 0; i < 8; i++) wave(10, 5);
    wave(12, 6);
    wave(10, 5);
    wave(10, 5);
    break_section("nominal");

    // Periods 9, 11, 12 against tolerance 0 and 1
    expect2(9,  1'b0, 1'b1, 1, 1'b1, 1'b0, 0);
    expect2(11, 1'b0, 1'b1, 2, 1'b1, 1'b0, 0);
    expect2(12, 1'b0, 1'b1, 3, 1'b0, 1'b1, 1);
    wave(9, 4);
    wave(11, 5);
    wave(12, 6);
    break_section("tolerance");

    // Five bad periods saturate a 2-bit error counter
    for (int i = 1; i <= 5; i++) expect2(12, 1'b0, 1'b1, (i > 3) ? 3 : i, 1'b0, 1'b1, (i > 3) ? 3 : i);
    for (int i = 0; i < 5; i++) wave(12, 6);
    chk("sat_a_ecnt_before_close", 32'(a_ecnt), 32'd3);
    break_section("saturate");

    // Stall: stuck exactly 64 cycles after the last counted rise
    wave(10, 5);
    chk_counts("rearm_first_edge");
    expect2(10, 1'b1, 1'b0, 0, 1'b1, 1'b0, 0);
    meas_in = 1'b1;
    repeat (5) tick();
    meas_in = 1'b0;
    repeat (61) tick();
    chk("stuck_a_before", 32'(a_stuck), 32'd0);
    chk("stuck_b_before", 32'(b_stuck), 32'd0);
    tick();
    chk("stuck_a_set", 32'(a_stuck), 32'd1);
    chk("stuck_b_set", 32'(b_stuck), 32'd1);
    chk_counts("stuck_no_valid");
    meas_in = 1'b1;
    tick();
    tick();
    chk("stuck_a_held", 32'(a_stuck), 32'd1);
    tick();
    chk("stuck_a_clear", 32'(a_stuck), 32'd0);
    chk("stuck_b_clear", 32'(b_stuck), 32'd0);
    repeat (2) tick();
    meas_in = 1'b0;
    repeat (5) tick();
    expect2(10, 1'b1, 1'b0, 0, 1'b1, 1'b0, 0);
    expect2(10, 1'b1, 1'b0, 0, 1'b1, 1'b0, 0);
    wave(10, 5);
    break_section("resume");

    // Reset in the middle of a measurement
    expect2(12, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1);
    expect2(10, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1);
    wave(12, 6);
    wave(10, 5);
    meas_in = 1'b1;
    repeat (5) tick();
    meas_in = 1'b0;
    repeat (2) tick();
    chk("pre_reset_a_ferr", 32'(a_ferr), 32'd1);
    reset = 1'b1;
    tick();
    chk_zero("mid_reset");
    reset = 1'b0;
    wave(10, 5);
    chk_counts("post_reset_one_edge");
    expect2(10, 1'b1, 1'b0, 0, 1'b1, 1'b0, 0);
    wave(10, 5);
    chk_counts("post_reset_two_edges");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
